// File: rtl/sys_debug_ctrl.sv
// Run-control and observation block for the single-cycle MIPS system: run/halt/step/load
// sequencing, PC breakpoints, enabled-cycle counting and a paged LED view of internal buses.
module sys_debug_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LED_W   = 27,
    parameter int NUM_SRC = 8,
    parameter int NUM_BP  = 4,
    parameter int STEP_W  = 16,
    localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                      SYS_clk,
    input  logic                      SYS_reset,
    input  logic                      SYS_run,
    input  logic                      SYS_halt,
    input  logic                      SYS_step,
    input  logic                      SYS_load,
    input  logic [STEP_W-1:0]         SYS_step_count,
    input  logic [DATA_W-1:0]         SYS_pc_load,
    input  logic                      bp_wr_en,
    input  logic [BP_IDX_W-1:0]       bp_wr_idx,
    input  logic [DATA_W-1:0]         bp_wr_addr,
    input  logic                      bp_wr_valid,
    input  logic [DATA_W-1:0]         pc_addr,
    input  logic [NUM_SRC*DATA_W-1:0] dbg_src,
    input  logic [7:0]                SYS_output_sel,
    input  logic                      SYS_page,
    output logic                      core_en,
    output logic                      pc_load_en,
    output logic [DATA_W-1:0]         pc_load_val,
    output logic [LED_W-1:0]          SYS_leds,
    output logic                      halted,
    output logic                      bp_hit,
    output logic [BP_IDX_W-1:0]       bp_hit_idx,
    output logic [31:0]               cycle_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cmd_q;
    logic [3:0]          w_cmd_edge;
    logic                r_run_first;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [DATA_W-1:0]   r_bp_addr [NUM_BP];
    logic [NUM_BP-1:0]   r_bp_valid;
    logic                w_bp_match;
    logic [BP_IDX_W-1:0] w_bp_idx;
    logic                w_bp_stop;
    logic [DATA_W-1:0]   w_src_word;
    logic [LED_W-1:0]    w_leds;
    logic                w_enter;

    // Order is {load, halt, step, run}; a command is its level's rising edge
    assign w_cmd_edge = {SYS_load, SYS_halt, SYS_step, SYS_run} & ~r_cmd_q;
    assign w_enter    = (w_next != r_state);

    // Lowest valid matching breakpoint wins, so scan from the top down
    always_comb begin
        w_bp_match = 1'b0;
        w_bp_idx   = {BP_IDX_W{1'b0}};
        for (int k = NUM_BP - 1; k >= 0; k--) begin
            if (r_bp_valid[k] && (r_bp_addr[k] == pc_addr)) begin
                w_bp_match = 1'b1;
                w_bp_idx   = BP_IDX_W'(k);
            end else begin
                w_bp_match = w_bp_match;
            end
        end
    end

    // The first RUN cycle ignores matches so a resume can step off the breakpoint
    assign w_bp_stop = (r_state == ST_RUN) && !r_run_first && w_bp_match;

    // Next-state decode; command priority is load > halt > step > run
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (w_cmd_edge[3])      w_next = ST_LOAD;
                else if (w_cmd_edge[2]) w_next = ST_HALT;
                else if (w_cmd_edge[1]) w_next = ST_STEP;
                else if (w_cmd_edge[0]) w_next = ST_RUN;
                else                    w_next = ST_HALT;
            end
            ST_RUN: begin
                if (w_cmd_edge[3])      w_next = ST_LOAD;
                else if (w_cmd_edge[2]) w_next = ST_HALT;
                else if (w_bp_stop)     w_next = ST_HALT;
                else                    w_next = ST_RUN;
            end
            ST_STEP: begin
                if (w_cmd_edge[3])                  w_next = ST_LOAD;
                else if (w_cmd_edge[2])             w_next = ST_HALT;
                else if (r_step_cnt <= STEP_W'(1))  w_next = ST_HALT;
                else                                w_next = ST_STEP;
            end
            ST_LOAD: w_next = ST_HALT;
            default: w_next = ST_HALT;
        endcase
    end

    // Core enable is a combinational decode so a breakpoint blocks the matching instruction
    always_comb begin
        core_en = 1'b0;
        case (r_state)
            ST_RUN:  core_en = !w_bp_stop;
            ST_STEP: core_en = 1'b1;
            default: core_en = 1'b0;
        endcase
    end

    // State register and per-state bookkeeping
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            r_state     <= ST_HALT;
            r_cmd_q     <= 4'b0000;
            r_run_first <= 1'b0;
            r_step_cnt  <= {STEP_W{1'b0}};
            halted      <= 1'b1;
            pc_load_en  <= 1'b0;
            pc_load_val <= {DATA_W{1'b0}};
        end else begin
            r_state     <= w_next;
            r_cmd_q     <= {SYS_load, SYS_halt, SYS_step, SYS_run};
            r_run_first <= w_enter && (w_next == ST_RUN);
            halted      <= (w_next == ST_HALT);
            pc_load_en  <= (w_next == ST_LOAD);
            if (w_enter && (w_next == ST_STEP)) begin
                r_step_cnt <= (SYS_step_count == {STEP_W{1'b0}}) ? STEP_W'(1) : SYS_step_count;
            end else if ((r_state == ST_STEP) && (w_next == ST_STEP)) begin
                r_step_cnt <= r_step_cnt - STEP_W'(1);
            end else begin
                r_step_cnt <= {STEP_W{1'b0}};
            end
            if (w_enter && (w_next == ST_LOAD)) begin
                pc_load_val <= SYS_pc_load;
            end else begin
                pc_load_val <= pc_load_val;
            end
        end
    end

    // Breakpoint table, stop status and the enabled-cycle counter
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            for (int k = 0; k < NUM_BP; k++) begin
                r_bp_addr[k] <= {DATA_W{1'b0}};
            end
            r_bp_valid  <= {NUM_BP{1'b0}};
            bp_hit      <= 1'b0;
            bp_hit_idx  <= {BP_IDX_W{1'b0}};
            cycle_count <= 32'd0;
        end else begin
            if (bp_wr_en) begin
                r_bp_addr[bp_wr_idx]  <= bp_wr_addr;
                r_bp_valid[bp_wr_idx] <= bp_wr_valid;
            end else begin
                r_bp_valid <= r_bp_valid;
            end
            if (w_enter && (w_next != ST_HALT)) begin
                bp_hit <= 1'b0;
            end else if (w_bp_stop) begin
                bp_hit     <= 1'b1;
                bp_hit_idx <= w_bp_idx;
            end else begin
                bp_hit <= bp_hit;
            end
            if (w_enter && (w_next == ST_LOAD)) begin
                cycle_count <= 32'd0;
            end else if (core_en) begin
                cycle_count <= cycle_count + 32'd1;
            end else begin
                cycle_count <= cycle_count;
            end
        end
    end

    // Display word: a paged source window, or the status word for out-of-range indices
    always_comb begin
        w_src_word = {DATA_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            w_src_word = (SYS_output_sel == 8'(k)) ? dbg_src[k*DATA_W +: DATA_W] : w_src_word;
        end
        if (SYS_output_sel < 8'(NUM_SRC)) begin
            if (SYS_page) begin
                w_leds = LED_W'(w_src_word[DATA_W-1:LED_W]);
            end else begin
                w_leds = w_src_word[LED_W-1:0];
            end
        end else begin
            w_leds = LED_W'({bp_hit_idx, bp_hit, r_state});
        end
    end

    // LED bank register
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            SYS_leds <= {LED_W{1'b0}};
        end else begin
            SYS_leds <= w_leds;
        end
    end

endmodule
